pipeline_stall_ctrl: RTL
========================

Name: pipeline_stall_ctrl

Overview:
Central freeze/flush scheduler for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB).
- Combines three inputs:
  - the hazard flag from hazard detection;
  - branch_taken from the EXE stage;
  - the MEM-stage SRAM handshake (mem_req/mem_ready).
- Produces one prioritised set of per-stage freeze/flush controls.
- Runs a memory-wait FSM with a timeout watchdog that latches a sticky error.

Parameters:
- MEM_TIMEOUT, 64, number of consecutive stalled memory cycles before mem_err is raised (must be ≥2).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- hazard  input  1  RAW hazard detected for the instruction in ID.
- branch_taken  input  1  branch resolved taken in EXE.
- mem_req  input  1  MEM stage holds a load or store.
- mem_ready  input  1  SRAM controller has completed the current access.
- freeze_all  output  1  hold every pipeline register and the PC.
- pc_freeze  output  1  hold the PC and the IF/ID register (hazard stall).
- if_id_flush  output  1  clear the IF/ID register to a bubble.
- id_exe_flush  output  1  clear the ID/EXE register to a bubble.
- mem_err  output  1  sticky memory-timeout error.
- hazard_stall_cnt  output  CNT_W  cycles stalled by hazard.
- mem_stall_cnt  output  CNT_W  cycles frozen by memory.
- flush_cnt  output  CNT_W  taken-branch flushes.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Registered state: FSM state, wait counter, mem_err, performance counters. All control outputs are combinational from state and current inputs (zero-cycle latency).
- Reset:
  - State → RUN, wait counter → 0, mem_err → 0, counters → 0.
  - While rst is high, all four control outputs are forced to 0.
- Define mstall = mem_req & ~mem_ready.
- FSM states: RUN, MEM_WAIT, ERROR.
  - RUN:
    - mstall → next MEM_WAIT, wait counter ← 1.
    - Otherwise stay in RUN.
  - MEM_WAIT:
    - mem_ready or ~mem_req → next RUN, counter ← 0.
    - mstall and counter == MEM_TIMEOUT-1 → next ERROR.
    - Otherwise counter ← counter + 1.
  - ERROR: absorbing until rst; mem_err = 1.
- Output priority (highest first):
  1. ERROR state: freeze_all = 1; all others 0.
  2. mstall: freeze_all = 1; pc_freeze, if_id_flush, id_exe_flush = 0. hazard and branch_taken are ignored because upstream registers are frozen and inputs stay stable.
  3. branch_taken: if_id_flush = 1, id_exe_flush = 1, pc_freeze = 0 (PC loads the target). A simultaneous hazard is ignored because the instruction in ID is squashed.
  4. hazard: pc_freeze = 1, id_exe_flush = 1 (bubble into EXE), if_id_flush = 0.
  5. Otherwise all outputs 0.
- Timing of mem_err: rises at the edge ending the MEM_TIMEOUT-th consecutive mstall cycle. Example: MEM_TIMEOUT = 8, mem_ready low for 8 cycles → mem_err high after the 8th edge.
- Memory completion: when mem_ready rises, freeze_all drops in the same cycle. A branch_taken or hazard still pending in EXE/ID takes effect in that same cycle.
- Back-to-back accesses: mem_ready=1 followed immediately by a new mstall re-enters MEM_WAIT with the counter restarted at 1.
- Reset mid-wait or in ERROR returns to RUN in one edge; mem_err clears.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - hazard_stall_cnt increments in cycles where priority level 4 is active.
  - mem_stall_cnt increments in cycles where freeze_all is due to mstall (not ERROR).
  - flush_cnt increments in cycles where level 3 is active.
  - All counters saturate at 2^CNT_W−1.
- Undefined: counter ports remain present and are tied to 0; no counter registers are synthesised.

Decomposition:
- Shared header pipe_ctrl_defs.vh holds:
  - state encodings STATE_RUN = 2'd0, STATE_MEM_WAIT = 2'd1, STATE_ERROR = 2'd2;
  - default MEM_TIMEOUT;
  - CNT_W.
- Wait-counter width is computed in the module as $clog2(MEM_TIMEOUT+1).
- One natural sub-module: sat_counter (parameter W; ports clk, rst, inc, count), instantiated three times inside the PIPE_PERF_CNT_EN guard.

Test Plan:
1. Reset then idle (all inputs 0) for 5 cycles → all control outputs 0, mem_err 0, counters 0.
2. hazard=1 for 2 cycles → pc_freeze=1 and id_exe_flush=1 both cycles; hazard_stall_cnt = 2.
3. hazard=1 together with branch_taken=1 for 1 cycle → if_id_flush=1, id_exe_flush=1, pc_freeze=0; flush_cnt = 1, hazard_stall_cnt unchanged.
4. mem_req=1, mem_ready=0 for 3 cycles with branch_taken=1, then mem_ready=1:
   - freeze_all=1 for exactly 3 cycles with no flush asserted;
   - flushes assert in the mem_ready cycle;
   - mem_stall_cnt = 3.
5. MEM_TIMEOUT=8, mem_req=1, mem_ready=0 for 10 cycles → mem_err=1 after the 8th edge; freeze_all stays 1 after mem_ready rises. Assert rst for 1 cycle → mem_err=0, state RUN.
6. Assert rst in the 2nd cycle of a memory wait → next cycle: counter 0, state RUN, freeze_all follows only current mstall.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl_pkg
// Shared definitions for the pipeline freeze/flush scheduler:
//   - state_t   : memory-wait FSM encoding (RUN / MEM_WAIT / ERROR)
//   - level_t   : which priority level currently drives the stage controls
//   - defaults  : MEM_TIMEOUT and performance-counter width
// -----------------------------------------------------------------------------
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        STATE_RUN      = 2'd0,
        STATE_MEM_WAIT = 2'd1,
        STATE_ERROR    = 2'd2
    } state_t;

    // Active priority level, highest first. LVL_NONE covers reset and idle.
    typedef enum logic [2:0] {
        LVL_NONE   = 3'd0,
        LVL_ERROR  = 3'd1,
        LVL_MEM    = 3'd2,
        LVL_BRANCH = 3'd3,
        LVL_HAZARD = 3'd4
    } level_t;

    localparam int DEFAULT_MEM_TIMEOUT = 64;
    localparam int DEFAULT_CNT_W       = 32;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the pipeline performance counters.
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset (clears count)
//   inc    in   increment request for this cycle
//   count  out  W-bit count, holds at all-ones once reached
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
// Central freeze/flush scheduler for the 5-stage pipeline (IF, ID, EXE, MEM,
// WB). Merges the ID hazard flag, the EXE taken-branch flag and the MEM-stage
// SRAM handshake into one prioritised set of stage controls, and watches
// memory stalls with a timeout that latches a sticky error.
//
// Optional feature (macro PIPE_PERF_CNT_EN): saturating performance counters
// for hazard stalls, memory freezes and branch flushes. Without the macro the
// counter ports exist but are tied to zero.
//
// Parameters:
//   MEM_TIMEOUT  consecutive stalled memory cycles before mem_err (>= 2)
//   CNT_W        performance counter width
// Ports:
//   clk               in   system clock
//   rst               in   synchronous active-high reset
//   hazard            in   RAW hazard on the instruction in ID
//   branch_taken      in   branch resolved taken in EXE
//   mem_req           in   MEM stage holds a load/store
//   mem_ready         in   SRAM access completed
//   freeze_all        out  hold every pipeline register and the PC
//   pc_freeze         out  hold PC and IF/ID (hazard stall)
//   if_id_flush       out  bubble the IF/ID register
//   id_exe_flush      out  bubble the ID/EXE register
//   mem_err           out  sticky memory-timeout error
//   hazard_stall_cnt  out  cycles stalled by hazard
//   mem_stall_cnt     out  cycles frozen by memory
//   flush_cnt         out  taken-branch flush cycles
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze_all,
    output logic             pc_freeze,
    output logic             if_id_flush,
    output logic             id_exe_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] hazard_stall_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              mstall;
    level_t            level;

    assign mstall = mem_req & ~mem_ready;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: all clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= STATE_RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            // ERROR is absorbing, so this stays high until rst.
            mem_err  <= (state_nxt == STATE_ERROR);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // The wait counter holds the number of consecutive mstall cycles already
    // completed; the RUN cycle that starts a wait counts as the first one.
    // -------------------------------------------------------------------------
    // NOTE: defaults at the top of every combinational block keep each output
    // assigned on all paths, so no latches are inferred.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        unique case (state)
            STATE_RUN: begin
                if (mstall) begin
                    state_nxt    = STATE_MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end else begin
                    wait_cnt_nxt = '0;
                end
            end
            STATE_MEM_WAIT: begin
                if (!mstall) begin
                    state_nxt    = STATE_RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_nxt    = STATE_ERROR;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            STATE_ERROR: begin
                state_nxt = STATE_ERROR;
            end
            default: begin
                state_nxt    = STATE_RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: pick the winning priority level, then decode it.
    // A memory stall in RUN freezes immediately (zero-cycle latency); once
    // mem_ready rises the pending branch/hazard acts in that same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        level = LVL_NONE;
        if (rst) begin
            level = LVL_NONE;
        end else if (state == STATE_ERROR) begin
            level = LVL_ERROR;
        end else if (mstall) begin
            level = LVL_MEM;
        end else if (branch_taken) begin
            // Instruction in ID is squashed, so a concurrent hazard is moot.
            level = LVL_BRANCH;
        end else if (hazard) begin
            level = LVL_HAZARD;
        end
    end

    always_comb begin
        freeze_all   = 1'b0;
        pc_freeze    = 1'b0;
        if_id_flush  = 1'b0;
        id_exe_flush = 1'b0;
        unique case (level)
            LVL_ERROR,
            LVL_MEM: begin
                freeze_all = 1'b1;
            end
            LVL_BRANCH: begin
                if_id_flush  = 1'b1;
                id_exe_flush = 1'b1;
            end
            LVL_HAZARD: begin
                pc_freeze    = 1'b1;
                id_exe_flush = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
    sat_counter #(.W(CNT_W)) u_hazard_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (level == LVL_HAZARD),
        .count (hazard_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mem_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (level == LVL_MEM),
        .count (mem_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (level == LVL_BRANCH),
        .count (flush_cnt)
    );
`else
    assign hazard_stall_cnt = '0;
    assign mem_stall_cnt    = '0;
    assign flush_cnt        = '0;
`endif

endmodule
